// File: rtl/segment_swap_ctl.sv
// Segment swap controller: arms a transition to a new sequencer segment on a sync-index
// wrap, a system-time threshold, a GPIO rising edge or immediately (EXT auto-advance mode).
module segment_swap_ctl #(
  parameter int NUM_SEGMENT = 4,
  parameter int REP_WIDTH   = 16,
  parameter int TIME_WIDTH  = 56
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           REQ_VALID,
  input  logic [$clog2(NUM_SEGMENT)-1:0] REQ_SEGMENT,
  input  logic [7:0]                     REQ_MODE,
  input  logic [63:0]                    REQ_VALUE,
  input  logic [REP_WIDTH-1:0]           REQ_REP,
  output logic                           REQ_READY,
  input  logic                           IDX_WRAP,
  input  logic [TIME_WIDTH-1:0]          SYS_TIME,
  input  logic [3:0]                     GPIO_IN,
  output logic [$clog2(NUM_SEGMENT)-1:0] SEGMENT,
  output logic                           SWAP,
  output logic                           STOP,
  output logic                           ERR
);

  localparam int SEG_W = $clog2(NUM_SEGMENT);

  localparam logic [SEG_W-1:0]     LAST_SEG = SEG_W'(NUM_SEGMENT - 1);
  localparam logic [SEG_W-1:0]     SEG_ZERO = {SEG_W{1'b0}};
  localparam logic [REP_WIDTH-1:0] REP_INF  = {REP_WIDTH{1'b1}};
  localparam logic [REP_WIDTH-1:0] REP_ZERO = {REP_WIDTH{1'b0}};

  localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME = 8'h01;
  localparam logic [7:0] MODE_GPIO     = 8'h02;
  localparam logic [7:0] MODE_EXT      = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDX  = 3'd1,
    ST_WAIT_TIME = 3'd2,
    ST_WAIT_GPIO = 3'd3,
    ST_EXT_RUN   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [REP_WIDTH-1:0]  rep_q, rep_d;
  logic [REP_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  stop_q, stop_d;
  logic                  swap_q, swap_d;
  logic                  err_q, err_d;
  logic [SEG_W-1:0]      pend_seg_q, pend_seg_d;
  logic [TIME_WIDTH-1:0] pend_time_q, pend_time_d;
  logic [1:0]            pend_sel_q, pend_sel_d;
  logic [REP_WIDTH-1:0]  pend_rep_q, pend_rep_d;
  logic                  gpio_prev_q, gpio_prev_d;

  logic                  ready_s;
  logic                  req_ok_s;
  logic                  accept_ok_s;
  logic                  accept_bad_s;
  logic                  gpio_cur_s;
  logic                  auto_swap_s;
  logic                  swap_s;
  logic [SEG_W-1:0]      new_seg_s;
  logic [REP_WIDTH-1:0]  new_rep_s;
  logic [REP_WIDTH-1:0]  cnt_inc_s;

  function automatic logic mode_valid(input logic [7:0] mode);
    logic ok;
    case (mode)
      MODE_SYNC_IDX, MODE_SYS_TIME, MODE_GPIO, MODE_EXT: ok = 1'b1;
      default:                                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic seg_in_range(input logic [SEG_W-1:0] seg);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SEGMENT; i++) begin
      if (seg == i[SEG_W-1:0]) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  function automatic logic [SEG_W-1:0] next_seg(input logic [SEG_W-1:0] seg);
    logic [SEG_W-1:0] nxt;
    if (seg == LAST_SEG) begin
      nxt = SEG_ZERO;
    end else begin
      nxt = seg + SEG_W'(1'b1);
    end
    return nxt;
  endfunction

  // Only the trigger time is kept from the request value; the upper bits are don't-care.
  if (TIME_WIDTH < 64) begin : g_value_unused
    logic unused_value_s;
    assign unused_value_s = ^REQ_VALUE[63:TIME_WIDTH];
  end

  assign req_ok_s     = mode_valid(REQ_MODE) & seg_in_range(REQ_SEGMENT);
  assign accept_ok_s  = ready_s & req_ok_s;
  assign accept_bad_s = ready_s & ~req_ok_s;
  assign gpio_cur_s   = GPIO_IN[pend_sel_q];
  assign cnt_inc_s    = (cnt_q == REP_INF) ? cnt_q : (cnt_q + REP_WIDTH'(1'b1));
  // The wrap that completes R+1 plays of the segment advances EXT mode.
  assign auto_swap_s  = (state_q == ST_EXT_RUN) & IDX_WRAP & (rep_q != REP_INF) & (cnt_q >= rep_q);

  // State register and all datapath flops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      seg_q       <= SEG_ZERO;
      rep_q       <= REP_INF;
      cnt_q       <= REP_ZERO;
      stop_q      <= 1'b0;
      swap_q      <= 1'b0;
      err_q       <= 1'b0;
      pend_seg_q  <= SEG_ZERO;
      pend_time_q <= {TIME_WIDTH{1'b0}};
      pend_sel_q  <= 2'b00;
      pend_rep_q  <= REP_ZERO;
      gpio_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      rep_q       <= rep_d;
      cnt_q       <= cnt_d;
      stop_q      <= stop_d;
      swap_q      <= swap_d;
      err_q       <= err_d;
      pend_seg_q  <= pend_seg_d;
      pend_time_q <= pend_time_d;
      pend_sel_q  <= pend_sel_d;
      pend_rep_q  <= pend_rep_d;
      gpio_prev_q <= gpio_prev_d;
    end
  end

  // Next state plus the swap decision; an accepted request overrides an EXT auto-advance.
  always_comb begin
    state_d   = state_q;
    swap_s    = 1'b0;
    new_seg_s = seg_q;
    new_rep_s = rep_q;
    case (state_q)
      ST_IDLE, ST_EXT_RUN: begin
        if (accept_ok_s) begin
          case (REQ_MODE)
            MODE_SYNC_IDX: state_d = ST_WAIT_IDX;
            MODE_SYS_TIME: state_d = ST_WAIT_TIME;
            MODE_GPIO:     state_d = ST_WAIT_GPIO;
            MODE_EXT: begin
              state_d   = ST_EXT_RUN;
              swap_s    = 1'b1;
              new_seg_s = REQ_SEGMENT;
              new_rep_s = REQ_REP;
            end
            default:       state_d = state_q;
          endcase
        end else if (auto_swap_s) begin
          swap_s    = 1'b1;
          new_seg_s = next_seg(seg_q);
          new_rep_s = rep_q;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT_IDX: begin
        if (IDX_WRAP) begin
          state_d   = ST_IDLE;
          swap_s    = 1'b1;
          new_seg_s = pend_seg_q;
          new_rep_s = pend_rep_q;
        end else begin
          state_d = ST_WAIT_IDX;
        end
      end
      ST_WAIT_TIME: begin
        if (SYS_TIME >= pend_time_q) begin
          state_d   = ST_IDLE;
          swap_s    = 1'b1;
          new_seg_s = pend_seg_q;
          new_rep_s = pend_rep_q;
        end else begin
          state_d = ST_WAIT_TIME;
        end
      end
      ST_WAIT_GPIO: begin
        if (gpio_cur_s && !gpio_prev_q) begin
          state_d   = ST_IDLE;
          swap_s    = 1'b1;
          new_seg_s = pend_seg_q;
          new_rep_s = pend_rep_q;
        end else begin
          state_d = ST_WAIT_GPIO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the pending request; the GPIO history starts from the level seen at acceptance.
  always_comb begin
    pend_seg_d  = pend_seg_q;
    pend_time_d = pend_time_q;
    pend_sel_d  = pend_sel_q;
    pend_rep_d  = pend_rep_q;
    gpio_prev_d = gpio_cur_s;
    if (accept_ok_s) begin
      pend_seg_d  = REQ_SEGMENT;
      pend_time_d = REQ_VALUE[TIME_WIDTH-1:0];
      pend_sel_d  = REQ_VALUE[1:0];
      pend_rep_d  = REQ_REP;
      gpio_prev_d = GPIO_IN[REQ_VALUE[1:0]];
    end else begin
      pend_seg_d = pend_seg_q;
    end
  end

  // Active segment and repetition tracking; a wrap that causes a swap is not counted.
  always_comb begin
    seg_d  = seg_q;
    rep_d  = rep_q;
    cnt_d  = cnt_q;
    stop_d = stop_q;
    swap_d = swap_s;
    err_d  = accept_bad_s;
    if (swap_s) begin
      seg_d  = new_seg_s;
      rep_d  = new_rep_s;
      cnt_d  = REP_ZERO;
      stop_d = 1'b0;
    end else if (IDX_WRAP) begin
      cnt_d  = cnt_inc_s;
      stop_d = stop_q | ((state_q != ST_EXT_RUN) & (rep_q != REP_INF) & (cnt_inc_s > rep_q));
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Handshake: requests are taken only while no trigger is armed.
  always_comb begin
    ready_s = 1'b0;
    if (RST) begin
      ready_s = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_EXT_RUN: ready_s = REQ_VALID;
        default:             ready_s = 1'b0;
      endcase
    end
  end

  assign REQ_READY = ready_s;
  assign SEGMENT   = seg_q;
  assign SWAP      = swap_q;
  assign STOP      = stop_q;
  assign ERR       = err_q;

endmodule
